shift_sequencer: RTL and testbench

Upstream stimulus/control stage for the 4-bit rotate-right shifter (`q = in` rotated right by `shift`). On a valid/ready start handshake it loads a data word, then walks the shifter's `shift` input through 0..3 at a programmable step rate. In walk mode it also steps the word left by one bit after each full rotation sweep, for four words. It drives the shifter's `in` and `shift` ports directly and flags each new step, so a downstream checker knows when `q` holds a fresh result.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 116 +++++++++++
 tb/tb_shift_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Start handshake and shifter-drive bundle for shift_sequencer.
// The requester owns the start/stop side; the sequencer owns the shifter drive and status.
interface shift_sequencer_if #(
    parameter int unsigned DWIDTH = 4,
    parameter int unsigned SWIDTH = 2,
    parameter int unsigned PW     = 8
);
    logic              start_valid;
    logic              start_ready;
    logic [DWIDTH-1:0] start_data;
    logic              start_mode;
    logic [PW-1:0]     start_period;
    logic              stop;
    logic [DWIDTH-1:0] sh_in;
    logic [SWIDTH-1:0] sh_shift;
    logic              step_valid;
    logic              busy;
    logic              done;

    modport master (
        output start_valid, start_data, start_mode, start_period, stop,
        input  start_ready, sh_in, sh_shift, step_valid, busy, done
    );

    modport slave (
        input  start_valid, start_data, start_mode, start_period, stop,
        output start_ready, sh_in, sh_shift, step_valid, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Stimulus sequencer for a rotate-right shifter: walks the shift amount through a full sweep
// at a programmable step rate, optionally stepping the data word left after each sweep.
module shift_sequencer #(
    parameter int unsigned DWIDTH = 4,
    parameter int unsigned SWIDTH = 2,
    parameter int unsigned PW     = 8
) (
    input logic              clk,
    input logic              rst,
    shift_sequencer_if.slave bus
);
    localparam int unsigned       WCW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [SWIDTH-1:0] SHIFT_MAX = {SWIDTH{1'b1}};
    localparam logic [WCW-1:0]    WCNT_LAST = WCW'(DWIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [DWIDTH-1:0] r_sh_in;
    logic [SWIDTH-1:0] r_sh_shift;
    logic              r_step_valid;
    logic              r_done;
    logic [PW-1:0]     r_div;
    logic [PW-1:0]     r_period;
    logic [WCW-1:0]    r_wcnt;
    logic              r_mode;

    logic w_accept;
    logic w_boundary;
    logic w_at_max;
    logic w_walk_more;
    logic w_finish;

    // Decode handshake and step-boundary events; stop masks the boundary so it always wins.
    always_comb begin
        w_accept    = (r_state == StIdle) && bus.start_valid;
        w_boundary  = (r_state == StRun) && !bus.stop && (r_div == '0);
        w_at_max    = (r_sh_shift == SHIFT_MAX);
        w_walk_more = r_mode && (r_wcnt < WCNT_LAST);
        w_finish    = w_boundary && w_at_max && !w_walk_more;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only from idle, leave run on stop or on the final boundary.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (bus.start_valid) w_state_next = StRun;
            StRun:  if (bus.stop || w_finish) w_state_next = StIdle;
        endcase
    end

    // Datapath: load on accept, count down the divider, advance shift/word on each boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_in      <= '0;
            r_sh_shift   <= '0;
            r_step_valid <= 1'b0;
            r_done       <= 1'b0;
            r_div        <= '0;
            r_period     <= '0;
            r_wcnt       <= '0;
            r_mode       <= 1'b0;
        end else begin
            r_step_valid <= 1'b0;
            r_done       <= 1'b0;
            if (w_accept) begin
                r_sh_in      <= bus.start_data;
                r_sh_shift   <= '0;
                r_wcnt       <= '0;
                r_mode       <= bus.start_mode;
                r_period     <= bus.start_period;
                r_div        <= bus.start_period;
                r_step_valid <= 1'b1;
            end else if (r_state == StRun && !bus.stop) begin
                if (r_div != '0) begin
                    r_div <= r_div - PW'(1);
                end else begin
                    r_div <= r_period;
                    if (!w_at_max) begin
                        r_sh_shift   <= r_sh_shift + SWIDTH'(1);
                        r_step_valid <= 1'b1;
                    end else if (w_walk_more) begin
                        // Zero fill: bits walked off the MSB are lost, later words may be zero.
                        r_sh_in      <= r_sh_in << 1;
                        r_sh_shift   <= '0;
                        r_wcnt       <= r_wcnt + WCW'(1);
                        r_step_valid <= 1'b1;
                    end else begin
                        // sh_in/sh_shift deliberately hold their last step values.
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Outputs: ready/busy decode straight from state so ready reads 1 throughout reset.
    always_comb begin
        bus.start_ready = (r_state == StIdle);
        bus.busy        = (r_state == StRun);
        bus.sh_in       = r_sh_in;
        bus.sh_shift    = r_sh_shift;
        bus.step_valid  = r_step_valid;
        bus.done        = r_done;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: step-index reference model checked every cycle, plus directed
// scenarios with hand-computed expectations and a randomized soak.
module tb_shift_sequencer;
    localparam int unsigned DW = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned PW = 8;
    localparam int          S  = 4;  // sweep length

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    shift_sequencer_if #(.DWIDTH(DW), .SWIDTH(SW), .PW(PW)) bus ();

    shift_sequencer #(.DWIDTH(DW), .SWIDTH(SW), .PW(PW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rotate right, i.e. what the downstream shifter shows on q.
    function automatic logic [3:0] rotr(input logic [3:0] v, input logic [1:0] s);
        logic [7:0] w;
        w = {v, v} >> s;
        return w[3:0];
    endfunction

    // Reference model: a run is N steps of P+1 cycles; step k shows data << (k/S), shift k%S.
    bit            m_run   = 1'b0;
    int            m_t     = 0;
    int            m_n     = 0;
    int            m_p1    = 1;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_in    = '0;
    logic [SW-1:0] m_shift = '0;
    logic          m_sv    = 1'b0;
    logic          m_done  = 1'b0;

    initial begin
        int k;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 1'b0; m_t = 0; m_in = '0; m_shift = '0; m_sv = 1'b0; m_done = 1'b0;
            end else begin
                m_sv   = 1'b0;
                m_done = 1'b0;
                if (!m_run) begin
                    if (bus.start_valid) begin
                        m_run  = 1'b1;
                        m_t    = 0;
                        m_data = bus.start_data;
                        m_n    = bus.start_mode ? DW * S : S;
                        m_p1   = int'(bus.start_period) + 1;
                    end
                end else if (bus.stop) begin
                    m_run = 1'b0;
                end else begin
                    m_t++;
                    if (m_t == m_n * m_p1) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
                if (m_run) begin
                    k       = m_t / m_p1;
                    m_in    = DW'(m_data << (k / S));
                    m_shift = SW'(k % S);
                    m_sv    = ((m_t % m_p1) == 0);
                end
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("start_ready", 32'(bus.start_ready), 32'(!m_run));
            chk("busy",        32'(bus.busy),        32'(m_run));
            chk("sh_in",       32'(bus.sh_in),       32'(m_in));
            chk("sh_shift",    32'(bus.sh_shift),    32'(m_shift));
            chk("step_valid",  32'(bus.step_valid),  32'(m_sv));
            chk("done",        32'(bus.done),        32'(m_done));
        end
    end

    // Present a start for one cycle; returns at the first negedge after the accept edge.
    task automatic start_run(input logic [3:0] d, input logic m, input logic [7:0] p);
        bus.start_valid  = 1'b1;
        bus.start_data   = d;
        bus.start_mode   = m;
        bus.start_period = p;
        @(negedge clk);
        bus.start_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_q[4];
        logic [3:0] exp_w[4];
        int         sv_cnt;
        int         done_cnt;
        int         done_at;
        int         hs_n;
        logic       prev_done;
        logic [3:0] prev_data;

        exp_q = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
        exp_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        bus.start_valid  = 1'b0;
        bus.start_data   = '0;
        bus.start_mode   = 1'b0;
        bus.start_period = '0;
        bus.stop         = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_sh_in", 32'(bus.sh_in),       32'd0);
        chk("rst_shift", 32'(bus.sh_shift),    32'd0);
        chk("rst_sv",    32'(bus.step_valid),  32'd0);
        chk("rst_done",  32'(bus.done),        32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single sweep, period 0.
        start_run(4'b0001, 1'b0, 8'd0);
        sv_cnt = 0; done_at = -1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) chk($sformatf("sweep_q%0d", i), 32'(rotr(bus.sh_in, bus.sh_shift)),
                           32'(exp_q[i]));
            if (bus.step_valid) sv_cnt++;
            if (bus.done) done_at = i;
            @(negedge clk);
        end
        chk("sweep_steps",   32'(sv_cnt),   32'd4);
        chk("sweep_done_at", 32'(done_at),  32'd4);
        chk("sweep_busy",    32'(bus.busy), 32'd0);

        // Walk, period 1.
        start_run(4'b0001, 1'b1, 8'd1);
        sv_cnt = 0; done_at = -1;
        for (int i = 0; i < 36; i++) begin
            if (i % 8 == 0 && i < 32)
                chk($sformatf("walk_word%0d", i / 8), 32'(bus.sh_in), 32'(exp_w[i / 8]));
            if (bus.step_valid) sv_cnt++;
            if (bus.done) done_at = i;
            @(negedge clk);
        end
        chk("walk_steps",   32'(sv_cnt),  32'd16);
        chk("walk_done_at", 32'(done_at), 32'd32);

        // Stop on the boundary that ends step 6 (walk, period 3).
        start_run(4'b0001, 1'b1, 8'd3);
        repeat (27) @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_ready", 32'(bus.start_ready), 32'd1);
        chk("stop_busy",  32'(bus.busy),        32'd0);
        chk("stop_sh_in", 32'(bus.sh_in),       32'(4'b0010));
        chk("stop_shift", 32'(bus.sh_shift),    32'd2);
        sv_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.step_valid) sv_cnt++;
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        chk("stop_no_step", 32'(sv_cnt),   32'd0);
        chk("stop_no_done", 32'(done_cnt), 32'd0);

        // Handshake: start_valid held with changing data; next run starts right after done.
        bus.start_valid  = 1'b1;
        bus.start_mode   = 1'b0;
        bus.start_period = 8'd0;
        prev_done = 1'b0; prev_data = '0; hs_n = 0;
        for (int i = 0; i < 14; i++) begin
            if (prev_done) begin
                chk("hs_step_after_done", 32'(bus.step_valid), 32'd1);
                chk("hs_data_after_done", 32'(bus.sh_in),      32'(prev_data));
                hs_n++;
            end
            prev_done      = bus.done;
            bus.start_data = 4'($urandom);
            prev_data      = bus.start_data;
            @(negedge clk);
        end
        chk("hs_back_to_back_runs", 32'(hs_n), 32'd2);
        bus.start_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Asynchronous reset during step 5 of a walk.
        start_run(4'b1011, 1'b1, 8'd0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.start_ready), 32'd1);
        chk("arst_busy",  32'(bus.busy),        32'd0);
        chk("arst_sh_in", 32'(bus.sh_in),       32'd0);
        chk("arst_shift", 32'(bus.sh_shift),    32'd0);
        chk("arst_sv",    32'(bus.step_valid),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        start_run(4'b0110, 1'b0, 8'd2);
        done_at = -1;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) done_at = i;
            @(negedge clk);
        end
        chk("post_rst_done_at", 32'(done_at), 32'd12);

        // Randomized soak, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            bus.start_valid  = ($urandom_range(2, 0) == 0);
            bus.start_data   = 4'($urandom);
            bus.start_mode   = 1'($urandom);
            bus.start_period = 8'($urandom_range(2, 0));
            bus.stop         = ($urandom_range(23, 0) == 0);
            @(negedge clk);
        end
        bus.start_valid = 1'b0;
        bus.stop        = 1'b0;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
